// File: rtl/dsa_simd_pkg.sv
// Shared types and helpers for the bilinear-interpolation SIMD scheduler.
package dsa_simd_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_STEP_WAIT,
    S_REQ_FETCH,
    S_WAIT_FETCH,
    S_START_DP,
    S_WAIT_DP,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  // Lane index must be able to hold the full lane count SIMD_WIDTH.
  function automatic int lane_idx_w(input int sw);
    return $clog2(sw) + 1;
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/dsa_simd_sched_fsm_if.sv
// Control/handshake bundle between the SIMD scheduler, the register block and the fetch/datapath units.
interface dsa_simd_sched_fsm_if #(
  parameter int SIMD_WIDTH = 4,
  parameter int COORD_W    = 16,
  parameter int CNT_W      = 32
);
  import dsa_simd_pkg::*;
  localparam int LANE_IDX_W = lane_idx_w(SIMD_WIDTH);

  logic                  enable;
  logic                  abort;
  logic                  step_mode;
  logic                  step_go;
  logic [COORD_W-1:0]    img_width_out;
  logic [COORD_W-1:0]    img_height_out;
  logic                  fetch_req;
  logic                  fetch_done;
  logic                  dp_start;
  logic                  dp_done;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [LANE_IDX_W-1:0] wr_index;
  logic [SIMD_WIDTH-1:0] lane_mask;
  logic [COORD_W-1:0]    current_x;
  logic [COORD_W-1:0]    current_y;
  logic                  busy;
  logic                  ready;
  logic                  aborted;
  logic [CNT_W-1:0]      groups_done;
  logic [CNT_W-1:0]      stall_cycles;

  // master: the scheduler itself; slave: registers plus fetch/datapath/writer
  modport master (
    input  enable, abort, step_mode, step_go, img_width_out, img_height_out,
    input  fetch_done, dp_done, wr_ready,
    output fetch_req, dp_start, wr_valid, wr_index, lane_mask, current_x, current_y,
    output busy, ready, aborted, groups_done, stall_cycles
  );

  modport slave (
    output enable, abort, step_mode, step_go, img_width_out, img_height_out,
    output fetch_done, dp_done, wr_ready,
    input  fetch_req, dp_start, wr_valid, wr_index, lane_mask, current_x, current_y,
    input  busy, ready, aborted, groups_done, stall_cycles
  );
endinterface

// File: rtl/dsa_simd_lane_mask.sv
// Active-lane count and mask for a group starting at column x of a row of the given width.
module dsa_simd_lane_mask
  import dsa_simd_pkg::*;
#(
  parameter int SIMD_WIDTH = 4,
  parameter int COORD_W    = 16,
  parameter int LANE_IDX_W = lane_idx_w(SIMD_WIDTH)
) (
  input  logic [COORD_W-1:0]    width,
  input  logic [COORD_W-1:0]    x,
  output logic [LANE_IDX_W-1:0] lane_n,
  output logic [SIMD_WIDTH-1:0] lane_mask
);
  localparam logic [COORD_W:0] SW_EXT = (COORD_W + 1)'(SIMD_WIDTH);

  logic [COORD_W:0] remaining;

  assign remaining = {1'b0, width} - {1'b0, x};
  // Below SIMD_WIDTH the remainder always fits in the lane index width.
  assign lane_n    = (remaining >= SW_EXT) ? LANE_IDX_W'(SIMD_WIDTH)
                                           : remaining[LANE_IDX_W-1:0];

  for (genvar gi = 0; gi < SIMD_WIDTH; gi++) begin : g_mask
    assign lane_mask[gi] = (LANE_IDX_W'(gi) < lane_n);
  end

endmodule

// File: rtl/dsa_simd_sched_fsm.sv
// SIMD group scheduler: walks the output image in lane groups, sequencing fetch, datapath and
// per-lane writeback, with abort, single-step and performance counters.
module dsa_simd_sched_fsm
  import dsa_simd_pkg::*;
#(
  parameter int SIMD_WIDTH = 4,
  parameter int COORD_W    = 16,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dsa_simd_sched_fsm_if.master bus
);
  localparam int               LANE_IDX_W = lane_idx_w(SIMD_WIDTH);
  localparam logic [COORD_W:0] SW_EXT     = (COORD_W + 1)'(SIMD_WIDTH);
  localparam logic [COORD_W-1:0] ONE_C    = COORD_W'(1);

  state_t                state_reg;
  logic [COORD_W-1:0]    w_reg, h_reg, x_reg, y_reg;
  logic                  abort_pend_reg;
  logic [LANE_IDX_W-1:0] wr_index_reg;
  logic [SIMD_WIDTH-1:0] lane_mask_reg;
  logic                  busy_reg, ready_reg, aborted_reg;
  logic [CNT_W-1:0]      groups_done_reg, stall_cycles_reg;

  logic [LANE_IDX_W-1:0] lane_n;
  logic [SIMD_WIDTH-1:0] lane_mask_next;
  logic [COORD_W:0]      x_step;
  logic                  abort_now, last_col, last_row, last_lane, stall_cond;
  state_t                launch_state;

  dsa_simd_lane_mask #(
    .SIMD_WIDTH (SIMD_WIDTH),
    .COORD_W    (COORD_W),
    .LANE_IDX_W (LANE_IDX_W)
  ) u_lane_mask (
    .width     (w_reg),
    .x         (x_reg),
    .lane_n    (lane_n),
    .lane_mask (lane_mask_next)
  );

  // x_step is one bit wider so a group near the top of the coordinate range cannot wrap.
  assign x_step       = {1'b0, x_reg} + SW_EXT;
  assign last_col     = (x_step >= {1'b0, w_reg});
  assign last_row     = (y_reg == h_reg - ONE_C);
  assign last_lane    = (wr_index_reg == lane_n - LANE_IDX_W'(1));
  assign abort_now    = abort_pend_reg | bus.abort;
  assign launch_state = bus.step_mode ? S_STEP_WAIT : S_REQ_FETCH;
  assign stall_cond   = (state_reg == S_WAIT_FETCH) || (state_reg == S_WAIT_DP) ||
                        ((state_reg == S_WRITE) && !bus.wr_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      w_reg            <= '0;
      h_reg            <= '0;
      x_reg            <= '0;
      y_reg            <= '0;
      abort_pend_reg   <= 1'b0;
      wr_index_reg     <= '0;
      lane_mask_reg    <= '1;
      busy_reg         <= 1'b0;
      ready_reg        <= 1'b0;
      aborted_reg      <= 1'b0;
      groups_done_reg  <= '0;
      stall_cycles_reg <= '0;
    end else begin
      if (busy_reg && bus.abort) abort_pend_reg <= 1'b1;
      if (stall_cond) stall_cycles_reg <= CNT_W'(sat_inc(64'(stall_cycles_reg), CNT_W));

      unique case (state_reg)
        S_IDLE: if (bus.enable) begin
          w_reg            <= bus.img_width_out;
          h_reg            <= bus.img_height_out;
          x_reg            <= '0;
          y_reg            <= '0;
          groups_done_reg  <= '0;
          stall_cycles_reg <= '0;
          aborted_reg      <= 1'b0;
          abort_pend_reg   <= 1'b0;
          busy_reg         <= 1'b1;
          state_reg        <= S_INIT;
        end
        S_INIT: begin
          if (w_reg == '0 || h_reg == '0) begin
            state_reg <= S_DONE; busy_reg <= 1'b0; ready_reg <= 1'b1; abort_pend_reg <= 1'b0;
          end else if (abort_now) begin
            state_reg <= S_DONE; busy_reg <= 1'b0; aborted_reg <= 1'b1; abort_pend_reg <= 1'b0;
          end else begin
            state_reg <= launch_state;
          end
        end
        S_STEP_WAIT: begin
          lane_mask_reg <= lane_mask_next;
          if (abort_now) begin
            state_reg <= S_DONE; busy_reg <= 1'b0; aborted_reg <= 1'b1; abort_pend_reg <= 1'b0;
          end else if (bus.step_go) begin
            state_reg <= S_REQ_FETCH;
          end
        end
        S_REQ_FETCH: begin
          lane_mask_reg <= lane_mask_next;
          state_reg     <= S_WAIT_FETCH;
        end
        S_WAIT_FETCH: begin
          if (abort_now) begin
            state_reg <= S_DONE; busy_reg <= 1'b0; aborted_reg <= 1'b1; abort_pend_reg <= 1'b0;
          end else if (bus.fetch_done) begin
            state_reg <= S_START_DP;
          end
        end
        S_START_DP: begin
          wr_index_reg <= '0;
          state_reg    <= S_WAIT_DP;
        end
        S_WAIT_DP: begin
          if (abort_now) begin
            state_reg <= S_DONE; busy_reg <= 1'b0; aborted_reg <= 1'b1; abort_pend_reg <= 1'b0;
          end else if (bus.dp_done) begin
            state_reg <= S_WRITE;
          end
        end
        // Abort stays pending here so a group is always written in full.
        S_WRITE: if (bus.wr_ready) begin
          if (last_lane) state_reg <= S_NEXT;
          else           wr_index_reg <= wr_index_reg + LANE_IDX_W'(1);
        end
        S_NEXT: begin
          groups_done_reg <= CNT_W'(sat_inc(64'(groups_done_reg), CNT_W));
          if (last_col) begin
            x_reg <= '0;
            y_reg <= y_reg + ONE_C;
          end else begin
            x_reg <= x_step[COORD_W-1:0];
          end
          if (last_row && last_col) begin
            state_reg <= S_DONE; busy_reg <= 1'b0; ready_reg <= 1'b1; abort_pend_reg <= 1'b0;
          end else if (abort_now) begin
            state_reg <= S_DONE; busy_reg <= 1'b0; aborted_reg <= 1'b1; abort_pend_reg <= 1'b0;
          end else begin
            state_reg <= launch_state;
          end
        end
        S_DONE: if (!bus.enable) begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.fetch_req    = (state_reg == S_REQ_FETCH);
  assign bus.dp_start     = (state_reg == S_START_DP);
  assign bus.wr_valid     = (state_reg == S_WRITE);
  assign bus.wr_index     = wr_index_reg;
  assign bus.lane_mask    = lane_mask_reg;
  assign bus.current_x    = x_reg;
  assign bus.current_y    = y_reg;
  assign bus.busy         = busy_reg;
  assign bus.ready        = ready_reg;
  assign bus.aborted      = aborted_reg;
  assign bus.groups_done  = groups_done_reg;
  assign bus.stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_dsa_simd_sched_fsm.sv
// Directed self-checking bench for the SIMD scheduler (SIMD_WIDTH=4).
module tb_dsa_simd_sched_fsm;
  import dsa_simd_pkg::*;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [2:0]  idx;
    logic [3:0]  mask;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsa_simd_sched_fsm_if #(.SIMD_WIDTH(4), .COORD_W(16), .CNT_W(32)) bus ();

  dsa_simd_sched_fsm #(.SIMD_WIDTH(4), .COORD_W(16), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  wr_t  wr_q[$];
  logic [2:0] stall_idx_q[$];
  int   fetch_cnt = 0;
  int   xfer_cnt  = 0;
  logic hold_dp   = 1'b0;
  logic stall_arm = 1'b0;
  int   stall_left = 0;
  logic fetch_prev = 1'b0;
  logic dp_prev    = 1'b0;

  // Monitor away from the active edge.
  always @(negedge clk) begin
    if (bus.fetch_req) fetch_cnt++;
    if (bus.wr_valid && bus.wr_ready) begin
      wr_q.push_back('{x: bus.current_x, y: bus.current_y, idx: bus.wr_index, mask: bus.lane_mask});
      xfer_cnt++;
    end
    if (bus.wr_valid && !bus.wr_ready) stall_idx_q.push_back(bus.wr_index);
  end

  // Fetch/datapath answer one cycle after the request; optional 3-cycle writer stall after 2 lanes.
  always @(posedge clk) begin
    #1;
    bus.fetch_done = fetch_prev;
    fetch_prev     = bus.fetch_req;
    bus.dp_done    = dp_prev && !hold_dp;
    dp_prev        = bus.dp_start;
    if (stall_arm && xfer_cnt == 2) begin
      stall_arm  = 1'b0;
      stall_left = 3;
    end
    if (stall_left > 0) begin
      bus.wr_ready = 1'b0;
      stall_left--;
    end else begin
      bus.wr_ready = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required earlier finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    stall_idx_q.delete();
    fetch_cnt = 0;
    xfer_cnt  = 0;
  endtask

  task automatic start_run(input logic [15:0] w, input logic [15:0] h);
    clear_mon();
    bus.img_width_out  = w;
    bus.img_height_out = h;
    bus.enable         = 1'b1;
  endtask

  task automatic wait_end(input int max_cycles);
    for (int i = 0; i < max_cycles && !(bus.ready || bus.aborted); i++) tick();
  endtask

  task automatic end_run();
    bus.enable = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
    n_cmp++; if (bus.lane_mask !== 4'hF) begin n_bad++; $display("FAIL reset_mask: got %h want f", bus.lane_mask); end
    n_cmp++; if ({bus.fetch_req, bus.dp_start, bus.wr_valid} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {bus.fetch_req, bus.dp_start, bus.wr_valid}); end
    n_cmp++; if ({bus.groups_done, bus.stall_cycles} !== 64'd0) begin n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.groups_done, bus.stall_cycles); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full();
    wr_t exp;
    start_run(16'd8, 16'd2);
    wait_end(200);
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL full_ready: got %b want 1", bus.ready); end
    n_cmp++; if (bus.groups_done !== 32'd4) begin n_bad++; $display("FAIL full_groups: got %0d want 4", bus.groups_done); end
    n_cmp++; if (bus.stall_cycles !== 32'd8) begin n_bad++; $display("FAIL full_stalls: got %0d want 8", bus.stall_cycles); end
    n_cmp++; if (wr_q.size() !== 16) begin n_bad++; $display("FAIL full_nwrites: got %0d want 16", wr_q.size()); end
    for (int e = 0; e < 16 && e < wr_q.size(); e++) begin
      exp = '{x: 16'((e / 4) % 2 * 4), y: 16'(e / 8), idx: 3'(e % 4), mask: 4'hF};
      n_cmp++; if (wr_q[e] !== exp) begin n_bad++; $display("FAIL full_write%0d: got x=%0d y=%0d i=%0d m=%h want x=%0d y=%0d i=%0d m=%h", e, wr_q[e].x, wr_q[e].y, wr_q[e].idx, wr_q[e].mask, exp.x, exp.y, exp.idx, exp.mask); end
    end
    end_run();
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL full_idle_ready: got %b want 0", bus.ready); end
  endtask

  task automatic test_tail();
    logic [15:0] tx [10] = '{0, 0, 0, 0, 4, 4, 4, 4, 8, 8};
    logic [2:0]  ti [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    logic [3:0]  tm [10] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h3, 4'h3};
    start_run(16'd10, 16'd1);
    tick(); tick(); tick();
    bus.img_width_out = 16'd100;   // must be ignored mid-run
    wait_end(200);
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL tail_ready: got %b want 1", bus.ready); end
    n_cmp++; if (bus.groups_done !== 32'd3) begin n_bad++; $display("FAIL tail_groups: got %0d want 3", bus.groups_done); end
    n_cmp++; if (bus.lane_mask !== 4'h3) begin n_bad++; $display("FAIL tail_mask: got %h want 3", bus.lane_mask); end
    n_cmp++; if (wr_q.size() !== 10) begin n_bad++; $display("FAIL tail_nwrites: got %0d want 10", wr_q.size()); end
    for (int e = 0; e < 10 && e < wr_q.size(); e++) begin
      n_cmp++; if ({wr_q[e].x, wr_q[e].idx, wr_q[e].mask} !== {tx[e], ti[e], tm[e]}) begin n_bad++; $display("FAIL tail_write%0d: got x=%0d i=%0d m=%h want x=%0d i=%0d m=%h", e, wr_q[e].x, wr_q[e].idx, wr_q[e].mask, tx[e], ti[e], tm[e]); end
    end
    end_run();
  endtask

  task automatic test_wr_stall();
    start_run(16'd4, 16'd1);
    stall_arm = 1'b1;
    wait_end(100);
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready: got %b want 1", bus.ready); end
    n_cmp++; if (bus.stall_cycles !== 32'd5) begin n_bad++; $display("FAIL stall_cycles: got %0d want 5", bus.stall_cycles); end
    n_cmp++; if (stall_idx_q.size() !== 3) begin n_bad++; $display("FAIL stall_len: got %0d want 3", stall_idx_q.size()); end
    foreach (stall_idx_q[k]) begin
      n_cmp++; if (stall_idx_q[k] !== 3'd2) begin n_bad++; $display("FAIL stall_hold%0d: got %0d want 2", k, stall_idx_q[k]); end
    end
    n_cmp++; if (wr_q.size() !== 4) begin n_bad++; $display("FAIL stall_nwrites: got %0d want 4", wr_q.size()); end
    for (int e = 0; e < 4 && e < wr_q.size(); e++) begin
      n_cmp++; if (wr_q[e].idx !== 3'(e)) begin n_bad++; $display("FAIL stall_write%0d: got %0d want %0d", e, wr_q[e].idx, e); end
    end
    end_run();
  endtask

  task automatic test_abort_dp();
    hold_dp = 1'b1;
    start_run(16'd8, 16'd2);
    for (int i = 0; i < 20 && !bus.dp_start; i++) tick();
    n_cmp++; if (bus.dp_start !== 1'b1) begin n_bad++; $display("FAIL abdp_start: got %b want 1", bus.dp_start); end
    tick();                     // now in WAIT_DP
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_cmp++; if ({bus.aborted, bus.ready, bus.busy} !== 3'b100) begin n_bad++; $display("FAIL abdp_flags: got aborted,ready,busy=%b want 100", {bus.aborted, bus.ready, bus.busy}); end
    n_cmp++; if (bus.groups_done !== 32'd0) begin n_bad++; $display("FAIL abdp_groups: got %0d want 0", bus.groups_done); end
    n_cmp++; if (wr_q.size() !== 0) begin n_bad++; $display("FAIL abdp_writes: got %0d want 0", wr_q.size()); end
    hold_dp = 1'b0;
    end_run();
  endtask

  task automatic test_abort_write();
    start_run(16'd8, 16'd2);
    tick();
    n_cmp++; if (bus.aborted !== 1'b0) begin n_bad++; $display("FAIL abwr_clear: got %b want 0", bus.aborted); end
    for (int i = 0; i < 20 && !bus.wr_valid; i++) tick();
    n_cmp++; if (bus.wr_valid !== 1'b1) begin n_bad++; $display("FAIL abwr_valid: got %b want 1", bus.wr_valid); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    wait_end(50);
    n_cmp++; if ({bus.aborted, bus.ready, bus.busy} !== 3'b100) begin n_bad++; $display("FAIL abwr_flags: got aborted,ready,busy=%b want 100", {bus.aborted, bus.ready, bus.busy}); end
    n_cmp++; if (bus.groups_done !== 32'd1) begin n_bad++; $display("FAIL abwr_groups: got %0d want 1", bus.groups_done); end
    n_cmp++; if (wr_q.size() !== 4) begin n_bad++; $display("FAIL abwr_writes: got %0d want 4", wr_q.size()); end
    n_cmp++; if (fetch_cnt !== 1) begin n_bad++; $display("FAIL abwr_fetches: got %0d want 1", fetch_cnt); end
    end_run();
  endtask

  task automatic test_step();
    bus.step_mode = 1'b1;
    start_run(16'd8, 16'd1);
    repeat (10) tick();
    n_cmp++; if (fetch_cnt !== 0) begin n_bad++; $display("FAIL step_park_fetch: got %0d want 0", fetch_cnt); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL step_park_busy: got %b want 1", bus.busy); end
    bus.step_go = 1'b1;
    tick();
    bus.step_go = 1'b0;
    repeat (12) tick();
    n_cmp++; if (fetch_cnt !== 1) begin n_bad++; $display("FAIL step1_fetch: got %0d want 1", fetch_cnt); end
    n_cmp++; if (bus.groups_done !== 32'd1) begin n_bad++; $display("FAIL step1_groups: got %0d want 1", bus.groups_done); end
    n_cmp++; if (bus.current_x !== 16'd4) begin n_bad++; $display("FAIL step1_x: got %0d want 4", bus.current_x); end
    bus.step_go = 1'b1;
    tick();
    bus.step_go = 1'b0;
    wait_end(30);
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL step2_ready: got %b want 1", bus.ready); end
    n_cmp++; if ({fetch_cnt[7:0], wr_q.size()} !== {8'd2, 32'd8}) begin n_bad++; $display("FAIL step2_counts: got fetch=%0d writes=%0d want 2/8", fetch_cnt, wr_q.size()); end
    bus.step_mode = 1'b0;
    end_run();
  endtask

  task automatic test_zero();
    start_run(16'd0, 16'd5);
    tick();
    n_cmp++; if ({bus.busy, bus.ready} !== 2'b10) begin n_bad++; $display("FAIL zero_c1: got busy,ready=%b want 10", {bus.busy, bus.ready}); end
    tick();
    n_cmp++; if ({bus.busy, bus.ready} !== 2'b01) begin n_bad++; $display("FAIL zero_c2: got busy,ready=%b want 01", {bus.busy, bus.ready}); end
    n_cmp++; if (fetch_cnt !== 0) begin n_bad++; $display("FAIL zero_fetch: got %0d want 0", fetch_cnt); end
    end_run();
  endtask

  task automatic test_rst_mid();
    start_run(16'd8, 16'd1);
    for (int i = 0; i < 20 && !bus.wr_valid; i++) tick();
    n_cmp++; if (bus.wr_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_valid: got %b want 1", bus.wr_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.busy, bus.wr_valid, bus.wr_index, bus.current_x} !== {1'b0, 1'b0, 3'd0, 16'd0}) begin n_bad++; $display("FAIL rstmid_state: got busy=%b valid=%b idx=%0d x=%0d want 0/0/0/0", bus.busy, bus.wr_valid, bus.wr_index, bus.current_x); end
    n_cmp++; if (bus.lane_mask !== 4'hF) begin n_bad++; $display("FAIL rstmid_mask: got %h want f", bus.lane_mask); end
    bus.enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    start_run(16'd8, 16'd1);
    wait_end(100);
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL rerun_ready: got %b want 1", bus.ready); end
    n_cmp++; if (bus.groups_done !== 32'd2) begin n_bad++; $display("FAIL rerun_groups: got %0d want 2", bus.groups_done); end
    n_cmp++; if (wr_q.size() !== 8) begin n_bad++; $display("FAIL rerun_writes: got %0d want 8", wr_q.size()); end
    n_cmp++; if (bus.stall_cycles !== 32'd4) begin n_bad++; $display("FAIL rerun_stalls: got %0d want 4", bus.stall_cycles); end
    end_run();
  endtask

  initial begin
    bus.enable         = 1'b0;
    bus.abort          = 1'b0;
    bus.step_mode      = 1'b0;
    bus.step_go        = 1'b0;
    bus.img_width_out  = '0;
    bus.img_height_out = '0;
    bus.fetch_done     = 1'b0;
    bus.dp_done        = 1'b0;
    bus.wr_ready       = 1'b1;
    test_reset();
    test_full();
    test_tail();
    test_wr_stall();
    test_abort_dp();
    test_abort_write();
    test_step();
    test_zero();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
